// File: rtl/logistic.sv
// Sigmoid activation stage with valid/ready streaming: forward pass maps a Q8.8
// argument to a Q0.8 activation; training mode returns feedback * a*(1-a).
module logistic (
    input  logic        clock,
    input  logic        reset,
    input  logic        train,
    input  logic        argument_valid,
    input  logic [15:0] argument_data,
    output logic        argument_ready,
    input  logic        feedback_valid,
    input  logic [15:0] feedback_data,
    output logic        feedback_ready,
    output logic        activation_valid,
    output logic [7:0]  activation_data,
    input  logic        activation_ready,
    output logic        delta_valid,
    output logic [15:0] delta_data,
    input  logic        delta_ready
);

    typedef enum logic [1:0] {
        S_ARG = 2'd0,
        S_ACT = 2'd1,
        S_FBK = 2'd2,
        S_DLT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_train;
    logic [7:0]  r_act;
    logic [15:0] r_delta;
    logic        w_arg_xfer;
    logic        w_act_xfer;
    logic        w_fbk_xfer;
    logic        w_dlt_xfer;

    // Piecewise-linear sigmoid; negative arguments mirror around 0.5.
    function automatic logic [7:0] f_sigma(input logic [15:0] x);
        logic [15:0] abs_v;
        logic [8:0]  y_v;
        logic [8:0]  s_v;
        if (x == 16'h8000) begin
            abs_v = 16'h7FFF;
        end else if (x[15]) begin
            abs_v = 16'd0 - x;
        end else begin
            abs_v = x;
        end
        if (abs_v >= 16'd1280) begin
            y_v = 9'd256;
        end else if (abs_v >= 16'd608) begin
            y_v = 9'((abs_v >> 5) + 16'd216);
        end else if (abs_v >= 16'd256) begin
            y_v = 9'((abs_v >> 3) + 16'd160);
        end else begin
            y_v = 9'((abs_v >> 2) + 16'd128);
        end
        s_v = x[15] ? (9'd256 - y_v) : y_v;
        return s_v[8] ? 8'hFF : s_v[7:0];
    endfunction

    // delta = (feedback * a*(1-a)) >>> 8, floor rounding; d never exceeds 64.
    function automatic logic [15:0] f_delta(input logic [7:0] a, input logic [15:0] fb);
        logic [16:0]        p_v;
        logic [6:0]         d_v;
        logic signed [23:0] m_v;
        p_v = {9'd0, a} * (17'd256 - {9'd0, a});
        d_v = 7'(p_v >> 8);
        m_v = 24'($signed(fb)) * 24'($signed({1'b0, d_v}));
        return 16'(m_v >>> 8);
    endfunction

    assign w_arg_xfer = argument_valid & argument_ready;
    assign w_act_xfer = activation_valid & activation_ready;
    assign w_fbk_xfer = feedback_valid & feedback_ready;
    assign w_dlt_xfer = delta_valid & delta_ready;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_ARG;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ARG: begin
                if (w_arg_xfer) w_next = S_ACT;
                else            w_next = S_ARG;
            end
            S_ACT: begin
                if (w_act_xfer) w_next = r_train ? S_FBK : S_ARG;
                else            w_next = S_ACT;
            end
            S_FBK: begin
                if (w_fbk_xfer) w_next = S_DLT;
                else            w_next = S_FBK;
            end
            S_DLT: begin
                if (w_dlt_xfer) w_next = S_ARG;
                else            w_next = S_DLT;
            end
            default: w_next = S_ARG;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        argument_ready   = 1'b0;
        activation_valid = 1'b0;
        feedback_ready   = 1'b0;
        delta_valid      = 1'b0;
        case (r_state)
            S_ARG:   argument_ready   = 1'b1;
            S_ACT:   activation_valid = 1'b1;
            S_FBK:   feedback_ready   = 1'b1;
            S_DLT:   delta_valid      = 1'b1;
            default: argument_ready   = 1'b0;
        endcase
    end

    // Datapath registers: train mode, activation and delta captured on transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_train <= 1'b0;
            r_act   <= 8'd0;
            r_delta <= 16'd0;
        end else begin
            if (w_arg_xfer) begin
                r_train <= train;
                r_act   <= f_sigma(argument_data);
            end
            if (w_fbk_xfer) begin
                r_delta <= f_delta(r_act, feedback_data);
            end
        end
    end

    assign activation_data = r_act;
    assign delta_data      = r_delta;

endmodule

// File: tb/tb_logistic.sv
// Directed self-checking bench for the logistic activation stage.
module tb_logistic;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        train = 1'b0;
    logic        argument_valid = 1'b0;
    logic [15:0] argument_data = 16'h0000;
    logic        argument_ready;
    logic        feedback_valid = 1'b0;
    logic [15:0] feedback_data = 16'h0000;
    logic        feedback_ready;
    logic        activation_valid;
    logic [7:0]  activation_data;
    logic        activation_ready = 1'b0;
    logic        delta_valid;
    logic [15:0] delta_data;
    logic        delta_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logistic dut (
        .clock            (clock),
        .reset            (reset),
        .train            (train),
        .argument_valid   (argument_valid),
        .argument_data    (argument_data),
        .argument_ready   (argument_ready),
        .feedback_valid   (feedback_valid),
        .feedback_data    (feedback_data),
        .feedback_ready   (feedback_ready),
        .activation_valid (activation_valid),
        .activation_data  (activation_data),
        .activation_ready (activation_ready),
        .delta_valid      (delta_valid),
        .delta_data       (delta_data),
        .delta_ready      (delta_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Train is flipped after acceptance to show it is only sampled at transfer.
    task automatic send_arg(input logic [15:0] x, input logic t);
        int n = 0;
        while (!argument_ready && n < 20) begin step(); n++; end
        chk("arg_ready", {15'd0, argument_ready}, 16'd1);
        argument_data  = x;
        train          = t;
        argument_valid = 1'b1;
        step();
        argument_valid = 1'b0;
        argument_data  = 16'h0000;
        train          = ~t;
        chk("act_latency", {15'd0, activation_valid}, 16'd1);
    endtask

    task automatic get_act(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!activation_valid && n < 20) begin step(); n++; end
        chk("act_valid", {15'd0, activation_valid}, 16'd1);
        chk(tag, {8'd0, activation_data}, {8'd0, exp});
        activation_ready = 1'b1;
        step();
        activation_ready = 1'b0;
    endtask

    task automatic send_fb(input logic [15:0] fb);
        int n = 0;
        while (!feedback_ready && n < 20) begin step(); n++; end
        chk("fb_ready", {15'd0, feedback_ready}, 16'd1);
        feedback_data  = fb;
        feedback_valid = 1'b1;
        step();
        feedback_valid = 1'b0;
        feedback_data  = 16'h0000;
        chk("dlt_latency", {15'd0, delta_valid}, 16'd1);
    endtask

    task automatic get_dlt(input string tag, input logic [15:0] exp);
        int n = 0;
        while (!delta_valid && n < 20) begin step(); n++; end
        chk("dlt_valid", {15'd0, delta_valid}, 16'd1);
        chk(tag, delta_data, exp);
        delta_ready = 1'b1;
        step();
        delta_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_arg_ready", {15'd0, argument_ready}, 16'd1);
        chk("rst_fb_ready", {15'd0, feedback_ready}, 16'd0);
        chk("rst_act_valid", {15'd0, activation_valid}, 16'd0);
        chk("rst_dlt_valid", {15'd0, delta_valid}, 16'd0);
        chk("rst_act_data", {8'd0, activation_data}, 16'h0000);
        chk("rst_dlt_data", delta_data, 16'h0000);
        reset = 1'b0;
        step();

        // Forward-only transaction
        send_arg(16'h0000, 1'b0);
        chk("act_arg_ready", {15'd0, argument_ready}, 16'd0);
        get_act("sig_0", 8'h80);
        chk("post_arg_ready", {15'd0, argument_ready}, 16'd1);
        chk("post_fb_ready", {15'd0, feedback_ready}, 16'd0);

        // Reset, then saturated training transaction
        reset = 1'b1; step(); reset = 1'b0; step();
        send_arg(16'h0600, 1'b1);
        get_act("sig_6", 8'hFF);
        chk("fbk_fb_ready", {15'd0, feedback_ready}, 16'd1);
        send_fb(16'hFE00);
        get_dlt("dlt_sat", 16'h0000);
        chk("dlt_done_arg_ready", {15'd0, argument_ready}, 16'd1);

        // Sigmoid segments and boundaries
        send_arg(16'hFA00, 1'b0); get_act("sig_m6", 8'h00);
        send_arg(16'h0100, 1'b0); get_act("sig_1", 8'hC0);
        send_arg(16'hFF00, 1'b0); get_act("sig_m1", 8'h40);
        send_arg(16'h8000, 1'b0); get_act("sig_min", 8'h00);
        send_arg(16'h7FFF, 1'b0); get_act("sig_max", 8'hFF);
        send_arg(16'h0300, 1'b0); get_act("sig_3", 8'hF0);
        send_arg(16'h04FF, 1'b0); get_act("sig_1279", 8'hFF);
        send_arg(16'h0260, 1'b0); get_act("sig_608", 8'hEB);
        send_arg(16'hFDA0, 1'b0); get_act("sig_m608", 8'h15);
        send_arg(16'h025F, 1'b0); get_act("sig_607", 8'hEB);
        send_arg(16'h0080, 1'b0); get_act("sig_half", 8'hA0);
        chk("train_ignored_fb", {15'd0, feedback_ready}, 16'd0);
        chk("train_ignored_arg", {15'd0, argument_ready}, 16'd1);

        // Delta values
        send_arg(16'h0000, 1'b1); get_act("sig_0_t", 8'h80);
        send_fb(16'h0100); get_dlt("dlt_p1", 16'h0040);
        send_arg(16'h0000, 1'b1); get_act("sig_0_t2", 8'h80);
        send_fb(16'hFE00); get_dlt("dlt_m2", 16'hFF80);
        send_arg(16'h0100, 1'b1); get_act("sig_1_t", 8'hC0);
        send_fb(16'hFF01); get_dlt("dlt_floor", 16'hFFD0);

        // Backpressure on activation and delta
        send_arg(16'h0100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_act_valid", {15'd0, activation_valid}, 16'd1);
            chk("bp_act_data", {8'd0, activation_data}, 16'h00C0);
            chk("bp_act_arg_ready", {15'd0, argument_ready}, 16'd0);
            step();
        end
        get_act("bp_act", 8'hC0);
        send_fb(16'h0100);
        for (int i = 0; i < 5; i++) begin
            chk("bp_dlt_valid", {15'd0, delta_valid}, 16'd1);
            chk("bp_dlt_data", delta_data, 16'h0030);
            chk("bp_dlt_fb_ready", {15'd0, feedback_ready}, 16'd0);
            chk("bp_dlt_arg_ready", {15'd0, argument_ready}, 16'd0);
            chk("bp_act_hold", {8'd0, activation_data}, 16'h00C0);
            step();
        end
        get_dlt("bp_dlt", 16'h0030);

        // Asynchronous reset while waiting for feedback
        send_arg(16'h0100, 1'b1); get_act("pre_rst_act", 8'hC0);
        chk("pre_rst_fb_ready", {15'd0, feedback_ready}, 16'd1);
        reset = 1'b1;
        #1;
        chk("arst_fb_ready", {15'd0, feedback_ready}, 16'd0);
        chk("arst_act_valid", {15'd0, activation_valid}, 16'd0);
        chk("arst_dlt_valid", {15'd0, delta_valid}, 16'd0);
        chk("arst_act_data", {8'd0, activation_data}, 16'h0000);
        chk("arst_dlt_data", delta_data, 16'h0000);
        step();
        reset = 1'b0;
        step();
        chk("arst_arg_ready", {15'd0, argument_ready}, 16'd1);
        chk("arst_fb_after", {15'd0, feedback_ready}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
